// File: rtl/hall_call_dispatch.sv
// Hall-call dispatcher for a two-car group: latches hall buttons, scans them
// round-robin and assigns each call to the cheaper car by distance/direction.
module hall_call_dispatch #(
    parameter int FLOORS = 5,
    parameter int POS_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] hall_req,
    input  logic [1:0]        car_en,
    input  logic [POS_W-1:0]  car0_pos,
    input  logic [POS_W-1:0]  car1_pos,
    input  logic              car0_up,
    input  logic              car0_dn,
    input  logic              car1_up,
    input  logic              car1_dn,
    input  logic              car0_door,
    input  logic              car1_door,
    output logic [FLOORS-1:0] car0_req,
    output logic [FLOORS-1:0] car1_req,
    output logic [FLOORS-1:0] hall_lamp,
    output logic              busy
);

    typedef enum logic {S_SCAN, S_ASSIGN} state_t;

    localparam logic [POS_W:0] PENALTY = (POS_W+1)'(FLOORS);
    localparam logic [POS_W-1:0] LAST  = POS_W'(FLOORS - 1);

    state_t            state;
    logic [FLOORS-1:0] pending, assigned, owner;
    logic [POS_W-1:0]  ptr, sel;
    logic              tie;

    logic [FLOORS-1:0] clr, cand, sel_hot;
    logic              hit;
    logic [POS_W-1:0]  hit_f;
    logic [POS_W:0]    d0, d1, cost0, cost1;
    logic              away0, away1, pick1, tie_used, abort;

    // owner is bookkeeping only: either car may serve a call
    logic unused_owner;
    assign unused_owner = ^owner;

    assign hall_lamp = pending;
    assign busy      = (state == S_ASSIGN);
    assign cand      = pending & ~assigned;

    always_comb begin
        clr = '0;
        for (int f = 0; f < FLOORS; f++)
            clr[f] = (car0_door && car0_pos == POS_W'(f)) ||
                     (car1_door && car1_pos == POS_W'(f));
    end

    // First candidate at or after ptr, wrapping around
    always_comb begin
        int idx;
        idx   = 0;
        hit   = 1'b0;
        hit_f = '0;
        for (int i = 0; i < FLOORS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= FLOORS) idx = idx - FLOORS;
            if (!hit && cand[idx]) begin
                hit   = 1'b1;
                hit_f = POS_W'(idx);
            end
        end
    end

    always_comb begin
        sel_hot      = '0;
        sel_hot[sel] = 1'b1;
        d0 = (car0_pos > sel) ? {1'b0, car0_pos} - {1'b0, sel} : {1'b0, sel} - {1'b0, car0_pos};
        d1 = (car1_pos > sel) ? {1'b0, car1_pos} - {1'b0, sel} : {1'b0, sel} - {1'b0, car1_pos};
        away0 = (car0_up && sel < car0_pos) || (car0_dn && sel > car0_pos);
        away1 = (car1_up && sel < car1_pos) || (car1_dn && sel > car1_pos);
        cost0 = d0 + (away0 ? PENALTY : '0);
        cost1 = d1 + (away1 ? PENALTY : '0);
        tie_used = 1'b0;
        if (car_en == 2'b01)      pick1 = 1'b0;
        else if (car_en == 2'b10) pick1 = 1'b1;
        else if (cost0 < cost1)   pick1 = 1'b0;
        else if (cost1 < cost0)   pick1 = 1'b1;
        else begin
            pick1    = tie;
            tie_used = 1'b1;
        end
        // a call already gone (cleared before this cycle) must not leave a stale assigned bit
        abort = clr[sel] || !pending[sel] || (car_en == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_SCAN;
            pending  <= '0;
            assigned <= '0;
            owner    <= '0;
            ptr      <= '0;
            sel      <= '0;
            tie      <= 1'b0;
            car0_req <= '0;
            car1_req <= '0;
        end else begin
            car0_req <= '0;
            car1_req <= '0;
            pending  <= (pending | hall_req) & ~clr;
            assigned <= assigned & ~clr;
            case (state)
                S_SCAN: begin
                    if (car_en != 2'b00 && hit) begin
                        sel   <= hit_f;
                        state <= S_ASSIGN;
                    end
                end
                S_ASSIGN: begin
                    state <= S_SCAN;
                    if (!abort) begin
                        if (pick1) car1_req <= sel_hot;
                        else       car0_req <= sel_hot;
                        assigned[sel] <= 1'b1;
                        owner[sel]    <= pick1;
                        ptr           <= (sel == LAST) ? '0 : sel + 1'b1;
                        if (tie_used) tie <= ~tie;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

endmodule
